// File: rtl/div_seq_pkg.sv
// Shared types and defaults for the sequential divider controller (div_seq).
package div_seq_pkg;

    localparam int DIV_SEQ_DATA_W         = 32;
    localparam int DIV_SEQ_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        COMMIT = 3'd3,
        EXC    = 3'd4
    } state_e;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO registers, written by a divider commit or by direct
// mthi/mtlo moves.
module hilo_reg
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_SEQ_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_i,
    input  logic              mthi_i,
    input  logic              mtlo_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] hi_div_i,
    input  logic [DATA_W-1:0] lo_div_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // Write mux; commit and direct moves never coincide because moves are gated to IDLE.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit_i) begin
            hi_d = hi_div_i;
            lo_d = lo_div_i;
        end else begin
            if (mthi_i) begin
                hi_d = wdata_i;
            end else begin
                hi_d = hi_q;
            end
            if (mtlo_i) begin
                lo_d = wdata_i;
            end else begin
                lo_d = lo_q;
            end
        end
    end

    // HI/LO state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/div_seq.sv
// Divide sequencer: issues one request to an external divider and commits
// HI/LO. Define DIV_SEQ_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W         = DIV_SEQ_DATA_W,
    parameter int TIMEOUT_CYCLES = DIV_SEQ_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    output logic              div_control,
    input  logic              div_stop,
    input  logic              div_zero,
    input  logic [DATA_W-1:0] hi_div,
    input  logic [DATA_W-1:0] lo_div,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              div_zero_exc,
    output logic              timeout
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] div_a_q, div_a_d;
    logic [DATA_W-1:0] div_b_q, div_b_d;
    logic              div_control_q;
    logic              busy_q;
    logic              done_q;
    logic              exc_q;
    logic              idle_s;

`ifdef DIV_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit_s;
    logic             timeout_q, timeout_d;

    // tmo_cnt_q counts completed WAIT cycles, so the limit is hit during the last allowed one.
    assign tmo_hit_s = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT cycle counter, restarted by every issue.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_d = tmo_cnt_q;
        end
    end
`endif

    // Next-state logic and operand capture.
    always_comb begin
        state_d = state_q;
        div_a_d = div_a_q;
        div_b_d = div_b_q;
`ifdef DIV_SEQ_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    div_a_d = rs_val;
                    div_b_d = rt_val;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A divider response wins over a limit reached in the same cycle.
                if (div_zero) begin
                    state_d = EXC;
                end else if (div_stop) begin
                    state_d = COMMIT;
`ifdef DIV_SEQ_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
`endif
                end else begin
                    state_d = WAIT;
                end
            end
            COMMIT:  state_d = IDLE;
            EXC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, operand and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            div_a_q       <= '0;
            div_b_q       <= '0;
            div_control_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            exc_q         <= 1'b0;
`ifdef DIV_SEQ_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            div_a_q       <= div_a_d;
            div_b_q       <= div_b_d;
            div_control_q <= (state_d == ISSUE);
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == COMMIT);
            exc_q         <= (state_d == EXC);
`ifdef DIV_SEQ_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign idle_s = (state_q == IDLE);

    hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk      (clk),
        .reset    (reset),
        .commit_i (state_q == COMMIT),
        .mthi_i   (mthi & idle_s),
        .mtlo_i   (mtlo & idle_s),
        .wdata_i  (wdata),
        .hi_div_i (hi_div),
        .lo_div_i (lo_div),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    assign div_a        = div_a_q;
    assign div_b        = div_b_q;
    assign div_control  = div_control_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign div_zero_exc = exc_q;
`ifdef DIV_SEQ_TIMEOUT_EN
    assign timeout      = timeout_q;
`else
    assign timeout      = 1'b0;
`endif

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before timeout (used only with DIV_SEQ_TIMEOUT_EN).
REQ-003 SHALL provide port clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL provide port reset  in  1  synchronous active-high reset.
REQ-005 SHALL provide port start  in  1  divide request from control unit.
REQ-006 SHALL provide ports rs_val, rt_val  in  DATA_W  dividend, divisor.
REQ-007 SHALL provide ports mthi, mtlo  in  1, and wdata  in  DATA_W, for direct HI/LO writes.
REQ-008 SHALL provide ports div_a, div_b  out  DATA_W  operands held to the divider.
REQ-009 SHALL provide port div_control  out  1  one-cycle divider start pulse.
REQ-010 SHALL provide ports div_stop, div_zero  in  1  and hi_div, lo_div  in  DATA_W, from the divider.
REQ-011 SHALL provide ports hi, lo  out  DATA_W  architectural HI/LO registers.
REQ-012 SHALL provide ports busy  out  1; done, div_zero_exc, timeout  out  1  one-cycle pulses.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, COMMIT, EXC.
REQ-014 IDLE: start=1 SHALL capture rs_val/rt_val into div_a/div_b and go to ISSUE; busy=0 only in IDLE.
REQ-015 ISSUE: div_control SHALL be 1 for exactly this one cycle, then go to WAIT; div_control=0 in every other state.
REQ-016 WAIT: div_stop/div_zero SHALL be sampled from the first WAIT cycle only (status from the previous operation is cleared by the ISSUE edge).
REQ-017 WAIT with div_zero=1 SHALL go to EXC (div_zero has priority over div_stop); div_stop=1 SHALL go to COMMIT; otherwise stay.
REQ-018 COMMIT SHALL load hi<=hi_div, lo<=lo_div, pulse done, return to IDLE; done therefore rises the cycle after div_stop is first seen.
REQ-019 EXC SHALL pulse div_zero_exc, leave HI/LO unchanged, return to IDLE.
REQ-020 start while busy=1 SHALL be ignored (no queueing).
REQ-021 mthi/mtlo SHALL write wdata to HI/LO only in IDLE; ignored while busy; if both are set, both are written.
REQ-022 start together with mthi/mtlo in IDLE: both SHALL take effect; the later COMMIT overwrites HI/LO.
REQ-023 div_a/div_b SHALL stay stable from ISSUE through the COMMIT/EXC exit.

Reset
REQ-024 reset SHALL force IDLE, hi=lo=0, div_a=div_b=0, div_control=busy=done=div_zero_exc=timeout=0, timeout counter=0.
REQ-025 reset in any state, including mid-WAIT, SHALL abort the operation with no done/exception pulse and no HI/LO update.

Configuration
REQ-026 With DIV_SEQ_TIMEOUT_EN defined: a WAIT cycle counter SHALL clear on ISSUE; if it reaches TIMEOUT_CYCLES without div_stop/div_zero, the block SHALL pulse timeout, leave HI/LO unchanged, and go to IDLE; a div_stop or div_zero in the same cycle the limit is reached takes priority.
REQ-027 Without DIV_SEQ_TIMEOUT_EN: no counter SHALL be present, timeout SHALL be tied 0, and WAIT SHALL be unbounded.

Structure
REQ-028 The shared package div_seq_pkg SHALL hold the state enum, the DATA_W default, and the TIMEOUT_CYCLES default.
REQ-029 HI/LO storage with the mthi/mtlo/commit write mux SHALL be the sub-module hilo_reg; the FSM stays in div_seq.

Verification
REQ-030 rs=7, rt=2, divider model -> div_control pulses once; after div_stop, done pulses with lo=3, hi=1.
REQ-031 rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done=1 for one cycle.
REQ-032 HI/LO preloaded with 0xAAAAAAAA via mthi/mtlo, then rt=0 -> div_zero_exc pulses once, no done, HI/LO remain 0xAAAAAAAA.
REQ-033 Second start 5 cycles into WAIT with different operands -> ignored: div_a/div_b unchanged, a single done pulse.
REQ-034 reset asserted 10 cycles into WAIT -> next cycle IDLE, hi=lo=0, no done pulse; a following 9/3 divide commits lo=3, hi=0.
REQ-035 Built with DIV_SEQ_TIMEOUT_EN and a stub divider that never responds -> timeout pulses after 64 WAIT cycles, busy falls, HI/LO unchanged.
